// File: rtl/dp_sum_processor.sv
// -----------------------------------------------------------------------------
// dp_sum_processor
//
// Purpose:
//   Dedicated processor (control FSM + datapath) that computes 1+2+...+N for a
//   runtime limit N. A run is requested with start while idle. The result
//   appears on outPort. A sticky overflow flag records any carry out of the
//   accumulator during the run.
//
// Parameters:
//   DATA_W    width of the accumulator and outPort
//   CNT_W     width of limit; the loop counter is CNT_W+1 bits so that
//             limit = 2^CNT_W-1 still terminates
//   OUT_MODE  0: outPort follows the accumulator on every ADD
//             1: outPort only changes when the run enters DONE
//
// Ports:
//   clk       in   1        single clock, rising edge
//   rst       in   1        synchronous, active-high reset
//   start     in   1        run request, honoured only in IDLE
//   limit     in   CNT_W    N, captured on the accepted start
//   busy      out  1        high in LOAD/CMP/ADD
//   done      out  1        one-cycle pulse while in DONE
//   overflow  out  1        sticky carry-out flag for the current/last run
//   outPort   out  DATA_W   registered result
//
// Timing: start accepted at cycle 0 -> LOAD at cycle 1 -> done at 2N+3.
// -----------------------------------------------------------------------------
module dp_sum_processor #(
  parameter int DATA_W   = 8,
  parameter int CNT_W    = 8,
  parameter int OUT_MODE = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [CNT_W-1:0]  limit,
  output logic              busy,
  output logic              done,
  output logic              overflow,
  output logic [DATA_W-1:0] outPort
);

  // State encoding
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LOAD = 3'd1;
  localparam logic [2:0] S_CMP  = 3'd2;
  localparam logic [2:0] S_ADD  = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  // The adder is wide enough for both operands plus a carry bit, whichever
  // of the accumulator and the counter is wider.
  localparam int OPD_W = (DATA_W > CNT_W + 1) ? DATA_W : (CNT_W + 1);
  localparam int ADD_W = OPD_W + 1;

  logic [2:0]        state_reg, state_next;
  logic [DATA_W-1:0] sum_reg,   sum_next;
  logic [CNT_W:0]    i_reg,     i_next;
  logic [CNT_W-1:0]  lim_reg,   lim_next;
  logic              ovf_reg,   ovf_next;
  logic [DATA_W-1:0] out_reg,   out_next;

  logic [ADD_W-1:0]  add_full;
  logic              add_carry;
  logic              cmp_go;

  // Datapath: accumulator + counter, and the loop-continue comparison.
  assign add_full  = ADD_W'(sum_reg) + ADD_W'(i_reg);
  // Any bit above the accumulator width means the sum wrapped this step.
  assign add_carry = |add_full[ADD_W-1:DATA_W];
  assign cmp_go    = (i_reg <= {1'b0, lim_reg});

  // Next-state and datapath control
  always_comb begin
    state_next = state_reg;
    sum_next   = sum_reg;
    i_next     = i_reg;
    lim_next   = lim_reg;
    ovf_next   = ovf_reg;
    out_next   = out_reg;

    case (state_reg)
      S_IDLE: begin
        if (start) begin
          lim_next   = limit;
          state_next = S_LOAD;
        end
      end

      S_LOAD: begin
        sum_next   = '0;
        i_next     = {{CNT_W{1'b0}}, 1'b1};
        ovf_next   = 1'b0;
        state_next = S_CMP;
      end

      S_CMP: begin
        if (cmp_go) begin
          state_next = S_ADD;
        end else begin
          out_next   = sum_reg;
          state_next = S_DONE;
        end
      end

      S_ADD: begin
        sum_next = add_full[DATA_W-1:0];
        i_next   = i_reg + 1'b1;
        if (add_carry) begin
          ovf_next = 1'b1;
        end
        if (OUT_MODE == 0) begin
          out_next = add_full[DATA_W-1:0];
        end
        state_next = S_CMP;
      end

      S_DONE: begin
        // start is deliberately not looked at here.
        state_next = S_IDLE;
      end

      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= S_IDLE;
      sum_reg   <= '0;
      i_reg     <= '0;
      lim_reg   <= '0;
      ovf_reg   <= 1'b0;
      out_reg   <= '0;
    end else begin
      state_reg <= state_next;
      sum_reg   <= sum_next;
      i_reg     <= i_next;
      lim_reg   <= lim_next;
      ovf_reg   <= ovf_next;
      out_reg   <= out_next;
    end
  end

  // Moore outputs: decoded from the state register only.
  assign busy     = (state_reg == S_LOAD) || (state_reg == S_CMP) || (state_reg == S_ADD);
  assign done     = (state_reg == S_DONE);
  assign overflow = ovf_reg;
  assign outPort  = out_reg;

endmodule

// File: tb/tb_dp_sum_processor.sv
// -----------------------------------------------------------------------------
// tb_dp_sum_processor
//
// Drives two instances (OUT_MODE=0 and OUT_MODE=1) with the same inputs and
// compares them cycle by cycle against a closed-form reference: after k ADD
// steps the accumulator holds k(k+1)/2 mod 256, overflow is set once that
// running total has reached 256, and done appears at cycle 2N+3.
// -----------------------------------------------------------------------------
module tb_dp_sum_processor;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] limit;
  logic       busy0, done0, ovf0;
  logic [7:0] out0;
  logic       busy1, done1, ovf1;
  logic [7:0] out1;

  int n_checks;
  int n_pass;

  // Reference state carried between runs
  int prev_out0;
  int prev_out1;
  int prev_ovf;

  dp_sum_processor #(.DATA_W(8), .CNT_W(8), .OUT_MODE(0)) dut0 (
    .clk(clk), .rst(rst), .start(start), .limit(limit),
    .busy(busy0), .done(done0), .overflow(ovf0), .outPort(out0)
  );

  dp_sum_processor #(.DATA_W(8), .CNT_W(8), .OUT_MODE(1)) dut1 (
    .clk(clk), .rst(rst), .start(start), .limit(limit),
    .busy(busy1), .done(done1), .overflow(ovf1), .outPort(out1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic int tri_sum(input int k);
    return k * (k + 1) / 2;
  endfunction

  function automatic int all_out(input int b0, input int d0, input int o0, input int p0,
                                 input int b1, input int d1, input int o1, input int p1);
    return b0 | d0 | o0 | p0 | b1 | d1 | o1 | p1;
  endfunction

  // One complete run of limit n. With noise=1 start/limit are toggled
  // randomly throughout the run, including during DONE.
  task automatic run(input int n, input bit noise);
    int final_sum;
    int final_ovf;
    int done_cyc;
    int k;
    int exp_out0;
    int exp_out1;
    int exp_ovf;
    string t;

    final_sum = tri_sum(n) % 256;
    final_ovf = (tri_sum(n) >= 256) ? 1 : 0;
    done_cyc  = 2 * n + 3;

    start = 1'b1;
    limit = 8'(n);
    @(posedge clk); #1;            // cycle 1
    start = 1'b0;

    for (int c = 1; c <= done_cyc; c++) begin
      // ADD steps completed before this cycle (first ADD is cycle 3).
      k = (c >= 4) ? (c - 2) / 2 : 0;
      if (k > n) k = n;

      if (c == done_cyc)  exp_out0 = final_sum;
      else if (k > 0)     exp_out0 = tri_sum(k) % 256;
      else                exp_out0 = prev_out0;

      exp_out1 = (c == done_cyc) ? final_sum : prev_out1;

      if (c == 1)         exp_ovf = prev_ovf;
      else                exp_ovf = (tri_sum(k) >= 256) ? 1 : 0;

      t = $sformatf("n%0d_c%0d", n, c);
      check_eq({t, "_busy0"}, int'(busy0), (c < done_cyc) ? 1 : 0);
      check_eq({t, "_done0"}, int'(done0), (c == done_cyc) ? 1 : 0);
      check_eq({t, "_out0"},  int'(out0),  exp_out0);
      check_eq({t, "_ovf0"},  int'(ovf0),  exp_ovf);
      check_eq({t, "_busy1"}, int'(busy1), (c < done_cyc) ? 1 : 0);
      check_eq({t, "_done1"}, int'(done1), (c == done_cyc) ? 1 : 0);
      check_eq({t, "_out1"},  int'(out1),  exp_out1);
      check_eq({t, "_ovf1"},  int'(ovf1),  exp_ovf);

      if (noise) begin
        start = 1'($urandom_range(0, 1));
        limit = 8'($urandom);
      end
      @(posedge clk); #1;
    end

    // Back in IDLE: results held, no second done, no restart.
    start = 1'b0;
    check_eq($sformatf("n%0d_idle_done", n), int'(done0), 0);
    check_eq($sformatf("n%0d_idle_out0", n), int'(out0), final_sum);
    check_eq($sformatf("n%0d_idle_out1", n), int'(out1), final_sum);
    check_eq($sformatf("n%0d_idle_ovf", n),  int'(ovf1), final_ovf);
    @(posedge clk); #1;
    check_eq($sformatf("n%0d_idle_busy", n), int'(busy0 | busy1 | done1), 0);
    $display("run limit=%0d sum=%0d ovf=%0d noise=%0d out0=%0d out1=%0d",
             n, final_sum, final_ovf, noise, out0, out1);

    prev_out0 = final_sum;
    prev_out1 = final_sum;
    prev_ovf  = final_ovf;
  endtask

  initial begin
    int dir_lim[8];
    n_checks  = 0;
    n_pass    = 0;
    prev_out0 = 0;
    prev_out1 = 0;
    prev_ovf  = 0;

    rst   = 1'b1;
    start = 1'b1;
    limit = 8'd7;
    repeat (3) @(posedge clk);
    #1;
    check_eq("reset_outputs",
             all_out(busy0, done0, ovf0, out0, busy1, done1, ovf1, out1), 0);
    rst   = 1'b0;
    start = 1'b0;
    @(posedge clk); #1;
    check_eq("reset_idle", int'(busy0 | busy1), 0);
    $display("reset check busy0=%0d out0=%0d", busy0, out0);

    // Directed limits: basic, zero, overflow edge, recover, noise run.
    dir_lim = '{10, 0, 22, 23, 3, 5, 10, 4};
    foreach (dir_lim[j]) begin
      run(dir_lim[j], (j == 5));
    end

    // Reset in the middle of a run (limit=10, inside an ADD cycle).
    start = 1'b1;
    limit = 8'd10;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;          // ends at cycle 5 (ADD)
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_eq("midrun_reset_outputs",
             all_out(busy0, done0, ovf0, out0, busy1, done1, ovf1, out1), 0);
    @(posedge clk); #1;
    check_eq("midrun_reset_stays_idle", int'(busy0 | done0), 0);
    $display("midrun reset out0=%0d out1=%0d busy0=%0d", out0, out1, busy0);
    prev_out0 = 0;
    prev_out1 = 0;
    prev_ovf  = 0;
    run(4, 1'b0);

    // Largest limit: counter must not wrap.
    run(255, 1'b0);

    // Randomised runs
    for (int r = 0; r < 20; r++) begin
      run(int'($urandom_range(0, 40)), 1'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
